// File: rtl/gateway_pkg.sv
// Shared definitions for the SPI-to-NoC gateway: opcodes, default field layout
// and a width-generic packet field extractor.
package gateway_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_WRITE = 4'd1;
    localparam logic [3:0] OP_READ  = 4'd2;

    localparam int OP_W         = 4;
    localparam int HDR_W        = 8;   // opcode plus four reserved bits ahead of X
    localparam int DEF_PKT_W    = 32;
    localparam int DEF_DATA_W   = 10;
    localparam int DEF_COORD_W  = 2;
    localparam int DEF_ROWS     = 10;
    localparam int DEF_ADDR_W   = $clog2(DEF_ROWS);

    localparam int DEF_OP_LSB   = DEF_PKT_W - OP_W;
    localparam int DEF_X_LSB    = DEF_PKT_W - HDR_W - DEF_COORD_W;
    localparam int DEF_Y_LSB    = DEF_X_LSB - DEF_COORD_W;
    localparam int DEF_ROW_LSB  = DEF_Y_LSB - DEF_ADDR_W;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] row;
        logic [31:0] data;
    } pkt_fields_t;

    function automatic logic [31:0] low_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Fields come back zero-extended so callers can compare against int parameters.
    function automatic pkt_fields_t unpack_pkt(input logic [127:0] pkt, input int pkt_w,
                                               input int coord_w, input int addr_w,
                                               input int data_w);
        pkt_fields_t f;
        int          x_lsb;
        x_lsb  = pkt_w - HDR_W - coord_w;
        f.op   = 4'(pkt >> (pkt_w - OP_W));
        f.x    = 32'(pkt >> x_lsb) & low_mask(coord_w);
        f.y    = 32'(pkt >> (x_lsb - coord_w)) & low_mask(coord_w);
        f.row  = 32'(pkt >> (x_lsb - coord_w - addr_w)) & low_mask(addr_w);
        f.data = 32'(pkt) & low_mask(data_w);
        return f;
    endfunction

endpackage

// File: rtl/gateway_fifo.sv
// Synchronous valid/ready FIFO; a push while full is accepted only if the head
// is popped in the same cycle.
module gateway_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_pop
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic [W-1:0]   r_mem [DEPTH];
    logic           w_wr_en;

    assign o_valid = (r_wr_ptr != r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_pop   = o_valid & i_ready;
    assign w_wr_en = i_push & (~o_full | o_pop);
    assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (o_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/spi_noc_gateway.sv
// SPI-slave gateway: deframes host packets, executes local row-SRAM accesses,
// forwards everything else to the router and returns read data on the next frame.
module spi_noc_gateway
    import gateway_pkg::*;
#(
    parameter int PKT_W      = DEF_PKT_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ROWS       = DEF_ROWS,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_spi_sck,
    input  logic             i_spi_cs_n,
    input  logic             i_spi_mosi,
    output logic             o_spi_miso,
    output logic             o_pkt_valid,
    input  logic             i_pkt_ready,
    output logic [PKT_W-1:0] o_pkt_data,
    input  logic             i_rsp_valid,
    output logic             o_rsp_ready,
    input  logic [PKT_W-1:0] i_rsp_data,
    output logic             o_rsp_pending,
    output logic             o_frame_err,
    output logic             o_ovf_err,
    output logic             o_addr_err
);
    localparam int ADDR_W = $clog2(ROWS);
    localparam int CNT_W  = $clog2(PKT_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(PKT_W + 1);

    logic [1:0]        r_sck_s, r_cs_s, r_mosi_s;
    logic              r_sck_d, r_cs_d;
    logic [PKT_W-1:0]  r_rx, r_tx, r_rsp;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_rsp_pending, r_frame_err, r_ovf_err, r_addr_err;
    logic [DATA_W-1:0] r_sram [ROWS];

    logic              w_sck, w_cs, w_mosi;
    logic              w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
    pkt_fields_t       w_f;
    logic              w_frame_ok, w_local, w_row_ok;
    logic              w_local_wr, w_local_rd, w_push;
    logic [ADDR_W-1:0] w_row;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_full, w_pop;

    assign w_sck      = r_sck_s[1];
    assign w_cs       = r_cs_s[1];
    assign w_mosi     = r_mosi_s[1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_cs_fall  = ~w_cs & r_cs_d;
    assign w_cs_rise  = w_cs & ~r_cs_d;

    always_comb begin
        w_f        = unpack_pkt({{(128-PKT_W){1'b0}}, r_rx}, PKT_W, COORD_W, ADDR_W, DATA_W);
        w_frame_ok = w_cs_rise && (r_bit_cnt == CNT_FULL);
        w_local    = (w_f.x == 32'(LOCAL_X)) && (w_f.y == 32'(LOCAL_Y));
        w_row_ok   = (w_f.row < 32'(ROWS));
        w_row      = ADDR_W'(w_f.row);
        w_rd_data  = w_row_ok ? r_sram[w_row] : '0;
        w_local_wr = w_frame_ok && w_local && (w_f.op == OP_WRITE);
        w_local_rd = w_frame_ok && w_local && (w_f.op == OP_READ);
        w_push     = w_frame_ok && (!w_local || (w_f.op > OP_READ));
    end

    // A local READ decode owns the response register this cycle; the NoC waits one.
    assign o_rsp_ready   = w_cs & ~w_local_rd;
    assign o_spi_miso    = r_tx[PKT_W-1];
    assign o_rsp_pending = r_rsp_pending;
    assign o_frame_err   = r_frame_err;
    assign o_ovf_err     = r_ovf_err;
    assign o_addr_err    = r_addr_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck_s  <= 2'b00;
            r_cs_s   <= 2'b11;
            r_mosi_s <= 2'b00;
            r_sck_d  <= 1'b0;
            r_cs_d   <= 1'b1;
        end else begin
            r_sck_s  <= {r_sck_s[0], i_spi_sck};
            r_cs_s   <= {r_cs_s[0], i_spi_cs_n};
            r_mosi_s <= {r_mosi_s[0], i_spi_mosi};
            r_sck_d  <= w_sck;
            r_cs_d   <= w_cs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx          <= '0;
            r_tx          <= '0;
            r_rsp         <= '0;
            r_bit_cnt     <= '0;
            r_rsp_pending <= 1'b0;
            r_frame_err   <= 1'b0;
            r_ovf_err     <= 1'b0;
            r_addr_err    <= 1'b0;
            for (int i = 0; i < ROWS; i++) r_sram[i] <= '0;
        end else begin
            r_frame_err <= w_cs_rise && (r_bit_cnt != CNT_FULL);
            r_addr_err  <= (w_local_wr || w_local_rd) && !w_row_ok;
            r_ovf_err   <= w_push && w_full && !w_pop;

            if (w_cs_fall) begin
                r_bit_cnt     <= '0;
                r_tx          <= r_rsp_pending ? r_rsp : '0;
                r_rsp_pending <= 1'b0;
            end else if (!w_cs) begin
                if (w_sck_rise) begin
                    r_rx <= {r_rx[PKT_W-2:0], w_mosi};
                    if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_sck_fall) r_tx <= {r_tx[PKT_W-2:0], 1'b0};
            end

            if (w_local_wr && w_row_ok) r_sram[w_row] <= DATA_W'(w_f.data);

            if (w_local_rd) begin
                r_rsp         <= {r_rx[PKT_W-1:DATA_W], w_rd_data};
                r_rsp_pending <= 1'b1;
            end else if (i_rsp_valid && o_rsp_ready) begin
                r_rsp         <= i_rsp_data;
                r_rsp_pending <= 1'b1;
            end
        end
    end

    gateway_fifo #(
        .W     (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (r_rx),
        .o_full  (w_full),
        .o_valid (o_pkt_valid),
        .i_ready (i_pkt_ready),
        .o_data  (o_pkt_data),
        .o_pop   (w_pop)
    );

endmodule

// File: tb/tb_spi_noc_gateway.sv
// Bench for spi_noc_gateway: SPI host driver, packet-level reference model,
// egress scoreboard and MISO/error-pulse checks.
module tb_spi_noc_gateway;
    localparam int ROWS = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        pkt_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'd0;
    logic        miso, pkt_valid, rsp_ready, rsp_pending, frame_err, ovf_err, addr_err;
    logic [31:0] pkt_data;

    int n_cmp = 0;
    int n_fail = 0;
    int cnt_ferr = 0, cnt_ovf = 0, cnt_aerr = 0;
    int exp_ferr = 0, exp_ovf = 0, exp_aerr = 0;

    logic [9:0]  m_sram [ROWS];
    logic [31:0] m_rsp;
    bit          m_pend;
    logic [31:0] exp_q[$];

    spi_noc_gateway dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_spi_sck     (sck),
        .i_spi_cs_n    (cs_n),
        .i_spi_mosi    (mosi),
        .o_spi_miso    (miso),
        .o_pkt_valid   (pkt_valid),
        .i_pkt_ready   (pkt_ready),
        .o_pkt_data    (pkt_data),
        .i_rsp_valid   (rsp_valid),
        .o_rsp_ready   (rsp_ready),
        .i_rsp_data    (rsp_data),
        .o_rsp_pending (rsp_pending),
        .o_frame_err   (frame_err),
        .o_ovf_err     (ovf_err),
        .o_addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) cnt_ferr++;
        if (ovf_err)   cnt_ovf++;
        if (addr_err)  cnt_aerr++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int i = 0; i < ROWS; i++) m_sram[i] = 10'd0;
        m_rsp  = 32'd0;
        m_pend = 1'b0;
        exp_q.delete();
    endfunction

    // Packet-level effect of a completed frame.
    function automatic void model_frame_end(input logic [31:0] p, input int nbits);
        int op, x, y, row;
        op  = int'(p[31:28]);
        x   = int'(p[23:22]);
        y   = int'(p[21:20]);
        row = int'(p[19:16]);
        if (nbits != 32) begin
            exp_ferr++;
        end else if (x == 0 && y == 0 && op == 1) begin
            if (row < ROWS) m_sram[row] = p[9:0];
            else exp_aerr++;
        end else if (x == 0 && y == 0 && op == 2) begin
            m_rsp  = {p[31:10], (row < ROWS) ? m_sram[row] : 10'd0};
            m_pend = 1'b1;
            if (row >= ROWS) exp_aerr++;
        end else if (x == 0 && y == 0 && op == 0) begin
            m_pend = m_pend;
        end else if (exp_q.size() < 4) begin
            exp_q.push_back(p);
        end else begin
            exp_ovf++;
        end
    endfunction

    function automatic logic [31:0] rand_pkt(input int kind);
        logic [31:0] p;
        p = $urandom();
        case (kind)
            0: begin p[31:28] = 4'd1; p[23:20] = 4'd0; p[19:16] = 4'($urandom_range(0, 15)); end
            1: begin p[31:28] = 4'd2; p[23:20] = 4'd0; p[19:16] = 4'($urandom_range(0, 15)); end
            2: begin p[31:28] = 4'd0; p[23:20] = 4'd0; end
            3: begin p[23:20] = 4'($urandom_range(1, 15)); end
            default: begin p[31:28] = 4'($urandom_range(3, 15)); p[23:20] = 4'd0; end
        endcase
        return p;
    endfunction

    task automatic spi_begin(output logic [31:0] exp_miso);
        exp_miso = m_pend ? m_rsp : 32'd0;
        m_pend   = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [63:0] p, input int nbits, output logic [31:0] got);
        got = 32'd0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = p[i];
            repeat (5) @(negedge clk);
            got = {got[30:0], miso};
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic spi_end(input logic [31:0] p, input int nbits);
        repeat (5) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (8) @(negedge clk);
        model_frame_end(p, nbits);
    endtask

    task automatic do_frame(input logic [63:0] p, input int nbits, input string tag,
                            output logic [31:0] got);
        logic [31:0] exp_m;
        spi_begin(exp_m);
        spi_bits(p, nbits, got);
        spi_end(p[31:0], nbits);
        if (nbits == 32) begin
            n_cmp++;
            if (got !== exp_m) begin
                n_fail++;
                $display("FAIL %s_miso: got %h required %h", tag, got, exp_m);
            end
        end
    endtask

    task automatic drain_fifo(input string tag);
        int          guard;
        logic [31:0] e;
        guard = 0;
        @(negedge clk);
        pkt_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 50) begin
            if (pkt_valid) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (pkt_data !== e) begin
                    n_fail++;
                    $display("FAIL %s_pop: got %h required %h", tag, pkt_data, e);
                end
            end
            guard++;
            @(negedge clk);
        end
        pkt_ready = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0 || pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain: left %0d valid %b required 0 0", tag, exp_q.size(), pkt_valid);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({miso, pkt_valid, pkt_data, rsp_pending, frame_err, ovf_err, addr_err} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got miso=%b v=%b d=%h p=%b e=%b%b%b required all 0",
                     miso, pkt_valid, pkt_data, rsp_pending, frame_err, ovf_err, addr_err);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rsp_ready: got %b required 1", rsp_ready);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] got;
        do_frame(64'h1000_0155, 32, "wr_row0", got);
        do_frame(64'h2000_0000, 32, "rd_row0", got);
        n_cmp++;
        if (rsp_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd_pending: got %b required 1", rsp_pending);
        end
        do_frame(64'h0000_0000, 32, "wr_rd_nop", got);
        n_cmp++;
        if (got !== 32'h2000_0155) begin
            n_fail++;
            $display("FAIL wr_rd_result: got %h required 20000155", got);
        end
    endtask

    task automatic test_egress();
        logic [31:0] got;
        do_frame(64'h1050_0001, 32, "egress", got);
        n_cmp++;
        if (pkt_valid !== 1'b1 || pkt_data !== 32'h1050_0001) begin
            n_fail++;
            $display("FAIL egress_head: got v=%b d=%h required v=1 d=10500001", pkt_valid, pkt_data);
        end
        drain_fifo("egress");
        do_frame(64'h2000_0000, 32, "egress_rd", got);
        do_frame(64'h0000_0000, 32, "egress_chk", got);
        n_cmp++;
        if (got !== 32'h2000_0155) begin
            n_fail++;
            $display("FAIL egress_sram: got %h required 20000155", got);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] got, p;
        int          ovf0;
        ovf0 = cnt_ovf;
        for (int i = 0; i < 5; i++) begin
            p = rand_pkt(3);
            do_frame({32'd0, p}, 32, "ovf", got);
        end
        n_cmp++;
        if (cnt_ovf - ovf0 != 1 || cnt_ovf != exp_ovf) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d required %0d", cnt_ovf - ovf0, 1);
        end
        drain_fifo("ovf");
    endtask

    task automatic test_frame_len();
        logic [31:0] got;
        do_frame(64'h0000_0000_1000_0077, 31, "len31", got);
        do_frame(64'h0000_0000_1000_0077, 33, "len33", got);
        n_cmp++;
        if (cnt_ferr != 2 || cnt_ferr != exp_ferr) begin
            n_fail++;
            $display("FAIL frame_err_count: got %0d required 2", cnt_ferr);
        end
        n_cmp++;
        if (pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_push: got %b required 0", pkt_valid);
        end
        do_frame(64'h2000_0000, 32, "len_rd", got);
        do_frame(64'h0000_0000, 32, "len_chk", got);
    endtask

    task automatic test_addr_err();
        logic [31:0] got;
        int          a0;
        a0 = cnt_aerr;
        do_frame(64'h100C_03FF, 32, "wr_row12", got);
        do_frame(64'h200C_0000, 32, "rd_row12", got);
        do_frame(64'h0000_0000, 32, "row12_nop", got);
        n_cmp++;
        if (got !== 32'h200C_0000) begin
            n_fail++;
            $display("FAIL row12_data: got %h required 200c0000", got);
        end
        n_cmp++;
        if (cnt_aerr - a0 != 2 || cnt_aerr != exp_aerr) begin
            n_fail++;
            $display("FAIL addr_err_count: got %0d required 2", cnt_aerr - a0);
        end
    endtask

    task automatic test_rsp();
        logic [31:0] exp_m, got;
        spi_begin(exp_m);
        rsp_data  = 32'hABCD_0123;
        rsp_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_ready_cs_low: got %b required 0", rsp_ready);
        end
        spi_bits(64'd0, 32, got);
        n_cmp++;
        if (rsp_ready !== 1'b0 || rsp_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_held_off: got ready=%b pending=%b required 0 0", rsp_ready, rsp_pending);
        end
        spi_end(32'd0, 32);
        rsp_valid = 1'b0;
        m_rsp     = 32'hABCD_0123;
        m_pend    = 1'b1;
        n_cmp++;
        if (rsp_pending !== 1'b1 || rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_accept: got pending=%b ready=%b required 1 1", rsp_pending, rsp_ready);
        end
        do_frame(64'd0, 32, "rsp_out", got);
        n_cmp++;
        if (got !== 32'hABCD_0123) begin
            n_fail++;
            $display("FAIL rsp_miso: got %h required abcd0123", got);
        end
    endtask

    task automatic test_random();
        logic [31:0] got, p;
        for (int i = 0; i < 30; i++) begin
            p = rand_pkt(int'($urandom_range(0, 4)));
            do_frame({32'd0, p}, 32, "rand", got);
            if (i % 6 == 5) drain_fifo("rand");
        end
        drain_fifo("rand_end");
        n_cmp++;
        if (cnt_ovf != exp_ovf || cnt_aerr != exp_aerr || cnt_ferr != exp_ferr) begin
            n_fail++;
            $display("FAIL rand_err_counts: got ovf=%0d addr=%0d frame=%0d required %0d %0d %0d",
                     cnt_ovf, cnt_aerr, cnt_ferr, exp_ovf, exp_aerr, exp_ferr);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] got;
        do_frame(64'h1003_02AA, 32, "mr_wr", got);
        do_frame(64'h1070_0042, 32, "mr_push", got);
        do_frame(64'h2003_0000, 32, "mr_rd", got);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(64'h0000_0000_1003_0155, 16, got);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({miso, pkt_valid, pkt_data, rsp_pending, frame_err, ovf_err, addr_err} !== 38'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got miso=%b v=%b d=%h p=%b e=%b%b%b required all 0",
                     miso, pkt_valid, pkt_data, rsp_pending, frame_err, ovf_err, addr_err);
        end
        cs_n  = 1'b1;
        sck   = 1'b0;
        mosi  = 1'b0;
        model_reset();
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (rsp_ready !== 1'b1 || pkt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_idle: got ready=%b valid=%b required 1 0", rsp_ready, pkt_valid);
        end
        do_frame(64'h2003_0000, 32, "mr_rd2", got);
        do_frame(64'h0000_0000, 32, "mr_chk", got);
        n_cmp++;
        if (got !== 32'h2003_0000) begin
            n_fail++;
            $display("FAIL midreset_sram: got %h required 20030000", got);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_egress();
        test_overflow();
        test_frame_len();
        test_addr_err();
        test_rsp();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_noc_gateway.md
Name: spi_noc_gateway

Overview:
- Parametrised, clk-synchronous SPI-slave gateway between an external host and the NoC mesh.
- SPI signals are oversampled on the system clock and packets are deframed. Packets addressed to this node are executed against a local row SRAM (WRITE/READ). All other packets are queued in an egress FIFO toward the router with a valid/ready handshake.
- Read data returned by the local SRAM or by the NoC is shifted out on MISO during the next SPI frame.

Parameters:
- PKT_W, 32, SPI frame and packet width in bits.
- DATA_W, 10, SRAM row width and packet data field width (LSBs of packet).
- ROWS, 10, local SRAM depth. ADDR_W = clog2(ROWS) = 4.
- COORD_W, 2, width of each mesh coordinate.
- LOCAL_X, 0, this node's X coordinate.
- LOCAL_Y, 0, this node's Y coordinate.
- FIFO_DEPTH, 4, egress FIFO entries (power of two, at least 2).
- Legal only if PKT_W >= 4 + 4 + 2*COORD_W + ADDR_W + DATA_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spi_sck  in  1  SPI clock, async to clk, mode 0
- spi_cs_n  in  1  SPI chip select, active low
- spi_mosi  in  1  SPI data in, MSB first
- spi_miso  out  1  SPI data out, MSB first
- pkt_valid  out  1  egress FIFO non-empty
- pkt_ready  in  1  router accepts head packet
- pkt_data  out  PKT_W  egress head packet
- rsp_valid  in  1  NoC read response offered
- rsp_ready  out  1  response accepted this cycle
- rsp_data  in  PKT_W  NoC read response packet
- rsp_pending  out  1  a response is loaded, awaiting a frame
- frame_err  out  1  one-cycle pulse: frame length not equal to PKT_W
- ovf_err  out  1  one-cycle pulse: packet dropped because FIFO full
- addr_err  out  1  one-cycle pulse: local row address >= ROWS

Behaviour:
- Packet fields:
  - [PKT_W-1 -: 4] opcode.
  - [PKT_W-9 -: COORD_W] X.
  - Next COORD_W bits: Y.
  - Next ADDR_W bits: row.
  - [DATA_W-1:0] data.
  - Opcodes: 0 NOP, 1 WRITE, 2 READ; others are opaque.
- Reset values:
  - All outputs 0, except rsp_ready, which is 1 once idle.
  - FIFO empty, SRAM rows cleared to 0, tx register 0, bit counter 0.
  - A reset mid-frame discards the frame.
- Synchronisation:
  - sck, cs_n and mosi pass through 2-flop synchronisers.
  - Edges are detected on the synchronised copies.
  - Required: sck high and low phases each >= 3 clk periods.
- Frame start (cs_n falling):
  - bit_cnt <= 0.
  - The tx shift register is loaded from the response register if rsp_pending is set, otherwise 0. rsp_pending then clears.
  - spi_miso presents tx[PKT_W-1] from the next clk.
- Shifting:
  - On sck rising: rx <= {rx, mosi}. bit_cnt increments and saturates at PKT_W+1.
  - On sck falling: tx shifts left and spi_miso <= the new MSB.
  - Edges while cs_n is high are ignored.
- Frame end (cs_n rising):
  - bit_cnt != PKT_W: frame_err pulse, packet discarded, no other effect.
  - Otherwise, decode in the same clk as the detected edge:
    - Local (X==LOCAL_X and Y==LOCAL_Y), WRITE: sram[row] <= data. If row >= ROWS, no write and addr_err pulses.
    - Local, READ: response register <= packet with the data field replaced by sram[row] (0 and addr_err if row >= ROWS). rsp_pending <= 1, overwriting any older response.
    - Local, NOP: dropped.
    - Non-local, any opcode, or local with an opcode outside {0,1,2}: push to FIFO. If full and no pop this cycle, the packet is dropped and ovf_err pulses.
- NoC responses:
  - rsp_ready = cs_n_sync high AND no local READ decode this cycle.
  - rsp_valid && rsp_ready loads the response register and sets rsp_pending; a newer response overwrites an older one.
  - A local READ decode beats a simultaneous rsp_valid, which is held off one cycle.
- Egress FIFO:
  - pkt_data is the head entry, registered.
  - Pop on pkt_valid && pkt_ready.
  - Simultaneous push and pop when full succeeds (no overflow).
  - Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package gateway_pkg:
  - Opcode constants OP_NOP, OP_WRITE, OP_READ.
  - Field offset/width localparams derived from PKT_W, COORD_W, ADDR_W, DATA_W.
  - A packet-field unpack function.
- One sub-module: gateway_fifo, a parametrised synchronous valid/ready FIFO with a full flag. Everything else stays in spi_noc_gateway.

Test Plan:
- Frame 0x1000_0155 (WRITE, X=0, Y=0, row 0, data 0x155), then frame 0x2000_0000 (READ row 0), then a NOP frame → MISO during the third frame shifts out 0x2000_0155.
- Frame 0x1050_0001 (X=1, Y=1) with pkt_ready=0 → pkt_valid=1, pkt_data=0x1050_0001, SRAM unchanged.
- Five non-local frames with pkt_ready held 0 and FIFO_DEPTH=4 → four entries queued, ovf_err pulses once on the fifth; then pkt_ready=1 pops them in order.
- 31-bit frame, then 33-bit frame → frame_err pulses twice, no FIFO push, no SRAM write.
- WRITE to row 12 (ROWS=10) → addr_err pulse, all rows remain 0. READ row 12 → response data 0 with addr_err.
- rsp_valid with rsp_data=0xABCD_0123 while cs_n is low → rsp_ready=0 until cs_n returns high, then the response is accepted and the next frame's MISO shifts out 0xABCD_0123. Assert rst_n mid-frame → all outputs return to reset values.
